// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, bit-period constants (period - 1),
// receiver state type and small helpers used by the RX datapath.
package uart_pkg;

  typedef logic [8:0] count_t;
  typedef logic [2:0] bc_t;

  localparam bc_t BC_9600   = 3'b000;
  localparam bc_t BC_19200  = 3'b001;
  localparam bc_t BC_38400  = 3'b010;
  localparam bc_t BC_57600  = 3'b011;
  localparam bc_t BC_115200 = 3'b100;

  localparam count_t BAUD_9600   = 9'd434;
  localparam count_t BAUD_19200  = 9'd217;
  localparam count_t BAUD_38400  = 9'd109;
  localparam count_t BAUD_57600  = 9'd72;
  localparam count_t BAUD_115200 = 9'd36;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  // Unlisted codes fall back to the slowest rate.
  function automatic count_t baud_max(input bc_t bc);
    case (bc)
      BC_19200:  baud_max = BAUD_19200;
      BC_38400:  baud_max = BAUD_38400;
      BC_57600:  baud_max = BAUD_57600;
      BC_115200: baud_max = BAUD_115200;
      default:   baud_max = BAUD_9600;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_fsm_if.sv
// Receiver-side bundle: serial line and configuration in, byte and status out.
// The slave modport is the receiver's view; master is the driving/consuming side.
interface uart_receiver_fsm_if;
  logic       Rxi;
  logic [2:0] BC;
  logic       PbitEna;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  Rxi, BC, PbitEna,
    output data_out, data_valid, parity_err, frame_err, busy
  );

  modport master (
    output Rxi, BC, PbitEna,
    input  data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for the UART receiver: latches the baud divisor when a frame
// starts and flags the half-bit and full-bit points of the running count.
module uart_rx_bit_timer
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  bc_t  bc,
  input  logic load,
  input  logic restart,
  input  logic run,
  output logic half_hit,
  output logic full_hit
);

  count_t cnt_q, cnt_d;
  count_t max_q, max_d;

  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    if (load) begin
      max_d = baud_max(bc);
      cnt_d = '0;
    end else if (restart) begin
      cnt_d = '0;
    end else if (run && (cnt_q != max_q)) begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      max_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
    end
  end

  assign half_hit = (cnt_q == (max_q >> 1));
  assign full_hit = (cnt_q == max_q);

endmodule

// File: rtl/uart_receiver_fsm.sv
// UART receiver: 2-flop synchroniser, frame FSM and shifter over uart_rx_bit_timer.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_receiver_fsm
  import uart_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  uart_receiver_fsm_if.slave  rx_if
);

  logic      rx_meta_q, rx_meta_d;
  logic      rx_sync_q, rx_sync_d;
  logic      rx_prev_q, rx_prev_d;
  rx_state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic      perr_acc_q, perr_acc_d;
  logic      ferr_acc_q, ferr_acc_d;
  logic [7:0] data_out_q, data_out_d;
  logic      data_valid_q, data_valid_d;
  logic      parity_err_q, parity_err_d;
  logic      frame_err_q, frame_err_d;
  logic      busy_q, busy_d;

  logic fall, sample;
  logic tmr_load, tmr_restart, tmr_run;
  logic half_hit, full_hit;

  uart_rx_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .bc       (rx_if.BC),
    .load     (tmr_load),
    .restart  (tmr_restart),
    .run      (tmr_run),
    .half_hit (half_hit),
    .full_hit (full_hit)
  );

  assign fall    = rx_prev_q & ~rx_sync_q;
  assign tmr_run = (state_q != IDLE);

  // rx_meta_q already holds the next synchronised value, so the majority window
  // around the nominal point is available without delaying the decision.
`ifdef UART_RX_MAJORITY_EN
  assign sample = maj3(rx_prev_q, rx_sync_q, rx_meta_q);
`else
  assign sample = rx_sync_q;
`endif

  always_comb begin
    rx_meta_d    = rx_if.Rxi;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    tmr_load     = 1'b0;
    tmr_restart  = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tmr_load   = 1'b1;
          busy_d     = 1'b1;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (half_hit) begin
          tmr_restart = 1'b1;
          idx_d       = 3'd0;
          if (!sample) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (full_hit) begin
          tmr_restart    = 1'b1;
          shift_d[idx_q] = sample;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (full_hit) begin
          tmr_restart = 1'b1;
          state_d     = STOP;
          if (rx_if.PbitEna) perr_acc_d = sample ^ (^shift_q);
          else if (!sample)  ferr_acc_d = 1'b1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a start bit right after one stop bit is caught.
        if (full_hit) begin
          tmr_restart  = 1'b1;
          state_d      = IDLE;
          busy_d       = 1'b0;
          data_valid_d = 1'b1;
          data_out_d   = shift_q;
          parity_err_d = perr_acc_q;
          frame_err_d  = ferr_acc_q | ~sample;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_if.data_out   = data_out_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Self-checking bench for uart_receiver_fsm: directed and random frames, with a
// line-history receiver model checked against the DUT outputs every cycle.
module tb_uart_receiver_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  uart_receiver_fsm_if bus ();

  uart_receiver_fsm dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  int unsigned cyc = 0;
  logic        rst_seen = 1'b0;
  bit          line [0:131071];
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      if (n_checks - n_pass >= 100) finish_run();
    end
  endtask

  function automatic int baud(input logic [2:0] bc);
    case (bc)
      3'd1: return 217;
      3'd2: return 109;
      3'd3: return 72;
      3'd4: return 36;
      default: return 434;
    endcase
  endfunction

  // ---------------- reference model over the recorded line ----------------
  logic       m_active = 1'b0;
  int         m_fall, m_bit, m_max;
  int         m_last = -1;
  int         m_ignore = 0;
  logic [7:0] m_byte;
  logic       m_pbit;
  logic       exp_valid = 1'b0, exp_busy = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0;
  logic [7:0] exp_data = '0;

  function automatic bit samp(input int s);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(line[s-1]) + int'(line[s]) + int'(line[s+1]);
    return (ones >= 2);
`else
    return line[s];
`endif
  endfunction

  // Bit b of a frame whose line fell at index f is sampled at line index
  // f + 1 + HALF + b*P; a new start needs its falling edge after the last sample.
  task automatic model_step(input int L);
    bit v;
    if (!m_active) begin
      if (line[L] == 1'b0 && line[L-1] == 1'b1 && L > m_last) begin
        m_active = 1'b1;
        m_fall   = L;
        m_bit    = 0;
        m_max    = baud(bus.BC);
      end
    end else if (L == m_fall + 1 + m_max / 2 + m_bit * (m_max + 1)) begin
      v = samp(L);
      if (m_bit == 0) begin
        if (v) begin
          m_active = 1'b0;
          m_last   = L;
        end
      end else if (m_bit <= 8) begin
        m_byte[m_bit-1] = v;
      end else if (m_bit == 9) begin
        m_pbit = v;
      end else begin
        exp_valid = 1'b1;
        exp_data  = m_byte;
        exp_perr  = bus.PbitEna && ((($countones(m_byte) + int'(m_pbit)) % 2) == 1);
        exp_ferr  = (!bus.PbitEna && !m_pbit) || !v;
        m_active  = 1'b0;
        m_last    = L;
      end
      m_bit++;
    end
  endtask

  // ---------------- per-cycle compare and monitor ----------------
  int         n_valid = 0;
  int         last_valid_cyc = -1;
  int         busy_fall_cyc = -1;
  logic [7:0] mon_data;
  logic       mon_perr, mon_ferr;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (cyc != 0) begin
      line[cyc] = bus.Rxi;
      exp_valid = 1'b0;
      if (rst_seen) begin
        m_active = 1'b0;
        exp_data = '0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        m_ignore = int'(cyc);
        m_last   = int'(cyc);
      end else if (int'(cyc) - 3 > m_ignore) begin
        model_step(int'(cyc) - 3);
      end
      exp_busy = m_active;
      chk("outputs{valid,busy,perr,ferr,data}",
          {20'd0, bus.data_valid, bus.busy, bus.parity_err, bus.frame_err, bus.data_out},
          {20'd0, exp_valid, exp_busy, exp_perr, exp_ferr, exp_data});
      if (bus.data_valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = int'(cyc);
        mon_data = bus.data_out;
        mon_perr = bus.parity_err;
        mon_ferr = bus.frame_err;
      end
      if (prev_busy && bus.busy === 1'b0) busy_fall_cyc = int'(cyc);
      prev_busy = (bus.busy === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  int fall_cyc;

  task automatic hold(input bit v, input int n);
    bus.Rxi = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop, input int p);
    fall_cyc = int'(cyc);
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    hold(pbit, p);
    hold(stop, p);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    bus.Rxi = 1'b1;
    bus.BC = 3'd0;
    bus.PbitEna = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", {24'd0, bus.data_out}, 32'h0);
    chk("reset_valid_busy", {30'd0, bus.data_valid, bus.busy}, 32'h0);
    chk("reset_errs", {30'd0, bus.parity_err, bus.frame_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 10);

    // 1: 0xA5 at 9600, correct even parity
    v0 = n_valid;
    send_frame(8'hA5, 1'b0, 1'b1, 435);
    hold(1'b1, 435);
    chk("t1_count", n_valid - v0, 1);
    chk("t1_data", {24'd0, mon_data}, 32'hA5);
    chk("t1_errs", {30'd0, mon_perr, mon_ferr}, 32'h0);
    chk("t1_latency", last_valid_cyc - fall_cyc, 4571);

    // 2: 0x3C at 115200 with wrong parity bit
    bus.BC = 3'd4;
    hold(1'b1, 40);
    v0 = n_valid;
    send_frame(8'h3C, 1'b1, 1'b1, 37);
    hold(1'b1, 40);
    chk("t2_count", n_valid - v0, 1);
    chk("t2_data", {24'd0, mon_data}, 32'h3C);
    chk("t2_errs", {30'd0, mon_perr, mon_ferr}, 32'h2);
    chk("t2_latency", last_valid_cyc - fall_cyc, 392);

    // 3: short glitch at 9600 is rejected at the start mid-bit
    bus.BC = 3'd0;
    hold(1'b1, 10);
    v0 = n_valid;
    busy_fall_cyc = -1;
    fall_cyc = int'(cyc);
    hold(1'b0, 10);
    hold(1'b1, 600);
    chk("t3_count", n_valid - v0, 0);
    chk("t3_busy_fall", busy_fall_cyc - fall_cyc, 221);

    // 4: 0x55 at 19200 with stop bit 0 and a break, then a clean 0x12
    bus.BC = 3'd1;
    hold(1'b1, 20);
    v0 = n_valid;
    hold(1'b0, 218);
    for (int i = 0; i < 8; i++) hold(((8'h55 >> i) & 8'h1) != 0, 218);
    hold(1'b0, 218);
    hold(1'b0, 3 * 218);
    hold(1'b1, 2 * 218);
    chk("t4_break_count", n_valid - v0, 1);
    chk("t4_break_data", {24'd0, mon_data}, 32'h55);
    chk("t4_break_errs", {30'd0, mon_perr, mon_ferr}, 32'h1);
    send_frame(8'h12, 1'b0, 1'b1, 218);
    hold(1'b1, 300);
    chk("t4_count", n_valid - v0, 2);
    chk("t4_data", {24'd0, mon_data}, 32'h12);
    chk("t4_errs", {30'd0, mon_perr, mon_ferr}, 32'h0);

    // 5: reset after data bit 3 of 0xFF, then a clean 0x81
    bus.BC = 3'd4;
    hold(1'b1, 40);
    v0 = n_valid;
    hold(1'b0, 37);
    for (int i = 0; i < 4; i++) hold(1'b1, 37);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_reset_data", {24'd0, bus.data_out}, 32'h0);
    chk("t5_reset_flags", {28'd0, bus.data_valid, bus.busy, bus.parity_err, bus.frame_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 80);
    chk("t5_abandoned", n_valid - v0, 0);
    send_frame(8'h81, 1'b0, 1'b1, 37);
    hold(1'b1, 60);
    chk("t5_count", n_valid - v0, 1);
    chk("t5_data", {24'd0, mon_data}, 32'h81);
    chk("t5_errs", {30'd0, mon_perr, mon_ferr}, 32'h0);

    // 6: back-to-back at 57600, parity slot used as a second stop bit
    bus.BC = 3'd3;
    bus.PbitEna = 1'b0;
    hold(1'b1, 80);
    v0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b1, 73);
    send_frame(8'hFF, 1'b1, 1'b1, 73);
    send_frame(8'h7E, 1'b1, 1'b1, 73);
    hold(1'b1, 100);
    chk("t6_count", n_valid - v0, 3);
    chk("t6_data", {24'd0, mon_data}, 32'h7E);
    chk("t6_errs", {30'd0, mon_perr, mon_ferr}, 32'h0);

    // unlisted baud code decodes to the 9600 divisor
    bus.BC = 3'd7;
    bus.PbitEna = 1'b1;
    hold(1'b1, 20);
    send_frame(8'hC3, 1'b0, 1'b1, 435);
    hold(1'b1, 300);
    chk("bc7_data", {24'd0, mon_data}, 32'hC3);
    chk("bc7_latency", last_valid_cyc - fall_cyc, 4571);

    // random frames, glitches, parity and stop errors
    for (int f = 0; f < 16; f++) begin
      int unsigned r;
      int p;
      logic [7:0] d;
      bit pb, st;
      r = $urandom_range(0, 9);
      bus.BC = (r < 4) ? 3'd4 : (r < 7) ? 3'd3 : 3'd2;
      bus.PbitEna = 1'($urandom_range(0, 1));
      p = baud(bus.BC) + 1;
      if ($urandom_range(0, 7) == 0) begin
        hold(1'b0, $urandom_range(1, baud(bus.BC) / 2 - 2));
        hold(1'b1, p);
      end else begin
        d  = 8'($urandom);
        pb = bus.PbitEna ? 1'($countones(d) % 2) : 1'b1;
        if ($urandom_range(0, 4) == 0) pb = ~pb;
        st = ($urandom_range(0, 5) != 0);
        send_frame(d, pb, st, p);
        if (!st) begin
          hold(1'b0, $urandom_range(0, p));
          hold(1'b1, $urandom_range(1, p));
        end else begin
          hold(1'b1, $urandom_range(0, p));
        end
      end
    end
    hold(1'b1, 600);
    finish_run();
  end

endmodule
